// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aud_pkg
//  Description : Shared definitions for the audio recorder slice: address and
//                sample widths, the last usable SRAM address, the recorder
//                state encoding and a saturating magnitude helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

    localparam int AUD_ADDR_W   = 20;
    localparam int AUD_SAMPLE_W = 16;
    localparam int AUD_BITCNT_W = 4;

    localparam logic [AUD_ADDR_W-1:0] AUD_ADDR_MAX = 20'hFFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_PAUSE = 3'd4
    } rec_state_t;

    // Magnitude of a two's-complement sample. The most negative value has no
    // positive counterpart in 16 bits, so it saturates to the largest positive.
    function automatic logic [AUD_SAMPLE_W-1:0] aud_abs_sat(input logic [AUD_SAMPLE_W-1:0] s);
        logic [AUD_SAMPLE_W-1:0] mag;
        if (s == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (s[AUD_SAMPLE_W-1]) begin
            mag = ~s + 16'd1;
        end else begin
            mag = s;
        end
        return mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aud_i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : aud_i2s_rx
//  Description : Left-channel I2S receiver. Detects the falling edge of LRC,
//                skips the one-bit I2S delay slot, shifts in 16 bits MSB
//                first and pulses o_valid for one cycle when the sample is
//                complete.
//  Ports       : i_clk, i_rst_n   - bit clock, asynchronous active-low reset
//                i_arm            - capture may start on an LRC fall this cycle
//                i_abort          - drop any partially shifted sample
//                i_lrc, i_data    - codec ADCLRCK / ADCDAT
//                o_lrc_fall       - combinational left-channel start indicator
//                o_sample         - assembled sample (valid with o_valid)
//                o_valid          - one-cycle sample-complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_i2s_rx
    import aud_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_arm,
    input  logic                    i_abort,
    input  logic                    i_lrc,
    input  logic                    i_data,
    output logic                    o_lrc_fall,
    output logic [AUD_SAMPLE_W-1:0] o_sample,
    output logic                    o_valid
);

    localparam logic [AUD_BITCNT_W-1:0] C_LAST_BIT = AUD_BITCNT_W'(AUD_SAMPLE_W - 1);

    logic                    r_prev_lrc;
    logic                    r_shifting;
    logic                    r_valid;
    logic [AUD_BITCNT_W-1:0] r_bit_cnt;
    logic [AUD_SAMPLE_W-1:0] r_shift;
    logic                    w_lrc_fall;

    // The fall cycle itself is the I2S delay bit, so shifting starts one
    // cycle later when r_shifting is already set.
    assign w_lrc_fall = r_prev_lrc & ~i_lrc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_lrc <= 1'b0;
            r_shifting <= 1'b0;
            r_valid    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_prev_lrc <= i_lrc;
            r_valid    <= 1'b0;
            if (i_abort) begin
                r_shifting <= 1'b0;
                r_bit_cnt  <= '0;
            end else if (r_shifting) begin
                r_shift <= {r_shift[AUD_SAMPLE_W-2:0], i_data};
                if (r_bit_cnt == C_LAST_BIT) begin
                    r_shifting <= 1'b0;
                    r_valid    <= 1'b1;
                    r_bit_cnt  <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (i_arm && w_lrc_fall) begin
                r_shifting <= 1'b1;
                r_bit_cnt  <= '0;
            end
        end
    end

    assign o_lrc_fall = w_lrc_fall;
    assign o_sample   = r_shift;
    assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/aud_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : aud_recorder
//  Description : Records left-channel I2S samples into SRAM. Owns the
//                recording state machine, SRAM addressing, end-address
//                tracking and the optional peak-magnitude meter.
//  Ports       : i_clk, i_rst_n          - bit clock, async active-low reset
//                i_start, i_stop         - one-cycle control pulses
//                i_pause                 - level, holds at sample boundary
//                i_lrc, i_data           - codec ADCLRCK / ADCDAT
//                o_address, o_data       - SRAM write address / sample
//                o_write                 - one-cycle write strobe
//                o_end_addr              - address of last written sample
//                o_full                  - memory exhausted
//                o_peak                  - peak |sample| since start
//  Build option: define AUD_REC_PEAK_EN to include the peak meter; without it
//                o_peak is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_recorder
    import aud_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_pause,
    input  logic                    i_stop,
    input  logic                    i_lrc,
    input  logic                    i_data,
    output logic [AUD_ADDR_W-1:0]   o_address,
    output logic [AUD_SAMPLE_W-1:0] o_data,
    output logic                    o_write,
    output logic [AUD_ADDR_W-1:0]   o_end_addr,
    output logic                    o_full,
    output logic [AUD_SAMPLE_W-1:0] o_peak
);

    rec_state_t              r_state;
    logic [AUD_ADDR_W-1:0]   r_address;
    logic [AUD_ADDR_W-1:0]   r_end_addr;
    logic [AUD_SAMPLE_W-1:0] r_data;
    logic                    r_write;
    logic                    r_full;

    logic                    w_arm;
    logic                    w_abort;
    logic                    w_lrc_fall;
    logic [AUD_SAMPLE_W-1:0] w_rx_sample;
    logic                    w_rx_valid;

    // The receiver may only start when the FSM will actually take the
    // S_WAIT -> S_SHIFT branch, i.e. stop and pause do not win this cycle.
    assign w_arm   = (r_state == S_WAIT) & ~i_stop & ~i_pause;
    assign w_abort = (r_state == S_SHIFT) & i_stop;

    aud_i2s_rx u_i2s_rx (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_arm      (w_arm),
        .i_abort    (w_abort),
        .i_lrc      (i_lrc),
        .i_data     (i_data),
        .o_lrc_fall (w_lrc_fall),
        .o_sample   (w_rx_sample),
        .o_valid    (w_rx_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_address  <= '0;
            r_end_addr <= '0;
            r_data     <= '0;
            r_write    <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_address <= '0;
                        r_full    <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (i_pause) begin
                        r_state <= S_PAUSE;
                    end else if (w_lrc_fall) begin
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Pause is deliberately ignored here: the sample in
                    // flight is finished and written before pausing.
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_rx_valid) begin
                        r_data  <= w_rx_sample;
                        r_write <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_end_addr <= r_address;
                    if (r_address == AUD_ADDR_MAX) begin
                        // Last word of SRAM: keep the address, flag full.
                        r_full  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_address <= r_address + 20'd1;
                        if (i_stop) begin
                            r_state <= S_IDLE;
                        end else if (i_pause) begin
                            r_state <= S_PAUSE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_PAUSE: begin
                    if (i_stop) begin
                        r_state <= S_IDLE;
                    end else if (!i_pause) begin
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AUD_REC_PEAK_EN
    logic [AUD_SAMPLE_W-1:0] r_peak;
    logic [AUD_SAMPLE_W-1:0] w_sample_mag;
    logic                    w_capture;
    logic                    w_clear;

    // Peak follows exactly the samples that are committed to memory: the
    // capture condition matches the S_SHIFT -> S_WRITE transition above.
    assign w_sample_mag = aud_abs_sat(w_rx_sample);
    assign w_capture    = (r_state == S_SHIFT) & ~i_stop & w_rx_valid;
    assign w_clear      = (r_state == S_IDLE) & i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_peak <= '0;
        end else if (w_clear) begin
            r_peak <= '0;
        end else if (w_capture && (w_sample_mag > r_peak)) begin
            r_peak <= w_sample_mag;
        end
    end

    assign o_peak = r_peak;
`else
    assign o_peak = '0;
`endif

    assign o_address  = r_address;
    assign o_data     = r_data;
    assign o_write    = r_write;
    assign o_end_addr = r_end_addr;
    assign o_full     = r_full;

endmodule
`default_nettype wire

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: codec bit clock (BCLK); the only clock; all logic on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port i_start, input, 1 bit: one-cycle pulse; begins a new recording.
REQ-004 SHALL have port i_pause, input, 1 bit: level; holds recording at the next sample boundary.
REQ-005 SHALL have port i_stop, input, 1 bit: one-cycle pulse; ends the recording.
REQ-006 SHALL have port i_lrc, input, 1 bit: codec ADCLRCK; 0 = left channel, the only channel recorded.
REQ-007 SHALL have port i_data, input, 1 bit: codec ADCDAT, I2S format, MSB first.
REQ-008 SHALL have port o_address, output, 20 bits: SRAM word address of the current or next write.
REQ-009 SHALL have port o_data, output, 16 bits: sample to be written.
REQ-010 SHALL have port o_write, output, 1 bit: SRAM write strobe, high for exactly one cycle per sample.
REQ-011 SHALL have port o_end_addr, output, 20 bits: address of the last written sample; feeds the playback DSP end address.
REQ-012 SHALL have port o_full, output, 1 bit: memory exhausted.
REQ-013 SHALL have port o_peak, output, 16 bits: peak magnitude (see Configuration).

Function
REQ-014 SHALL implement the states S_IDLE, S_WAIT, S_SHIFT, S_WRITE and S_PAUSE.
REQ-015 In S_IDLE, an i_start pulse SHALL clear the address to 0, clear o_full and o_peak, and move to S_WAIT; i_start in any other state SHALL be ignored.
REQ-016 S_WAIT SHALL detect a left-channel start (previous registered i_lrc=1, current i_lrc=0); that edge cycle is the I2S delay bit, SHALL NOT be captured, and SHALL move to S_SHIFT with bit count 0.
REQ-017 S_SHIFT SHALL shift i_data into the LSB of a 16-bit register on each of the next 16 rising edges; after the 16th bit it SHALL move to S_WRITE.
REQ-018 The first data bit SHALL be sampled 1 cycle after edge detection, and o_write SHALL be high 17 cycles after edge detection.
REQ-019 In S_WRITE, o_write SHALL be 1, o_data SHALL equal the assembled sample, and o_address SHALL be stable during the strobe.
REQ-020 On the cycle after S_WRITE, o_end_addr SHALL take the value of o_address, and o_address SHALL increment by 1.
REQ-021 At o_address = 20'hFFFFF, the write SHALL complete, o_address SHALL NOT wrap, o_full SHALL be set, and the state SHALL return to S_IDLE.
REQ-022 o_full SHALL hold until the next i_start.
REQ-023 An i_stop pulse in S_WAIT, S_SHIFT or S_PAUSE SHALL cause a return to S_IDLE on the next cycle; a partially shifted sample SHALL be discarded, and o_end_addr SHALL be unchanged.
REQ-024 An i_stop pulse during S_WRITE SHALL let that write complete, including the address and o_end_addr update, then the state SHALL go to S_IDLE.
REQ-025 i_pause SHALL be honoured only in S_WAIT and after S_WRITE (go to S_PAUSE); a sample in progress SHALL finish and be written first.
REQ-026 S_PAUSE SHALL return to S_WAIT when i_pause = 0.
REQ-027 i_stop SHALL take priority over i_pause.
REQ-028 o_write SHALL be 0 in every state except S_WRITE.
REQ-029 o_address and o_end_addr SHALL be held in S_IDLE after a recording, so that playback uses them.

Reset
REQ-030 When i_rst_n = 0, the block SHALL asynchronously go to S_IDLE, with o_address = 0, o_end_addr = 0, o_data = 0, o_write = 0, o_full = 0, o_peak = 0, bit count = 0 and prev_lrc = 0.
REQ-031 Reset mid-sample SHALL abort the sample with no write.

Configuration
REQ-032 With AUD_REC_PEAK_EN defined, o_peak SHALL update on each write to max(o_peak, |sample|), treating the sample as two's complement; 16'h8000 SHALL saturate to 16'h7FFF.
REQ-033 Without AUD_REC_PEAK_EN, o_peak SHALL be constant 0, and no peak logic SHALL be synthesised.

Structure
REQ-034 The shared package aud_pkg SHALL hold: AUD_ADDR_W = 20, AUD_SAMPLE_W = 16, AUD_ADDR_MAX = 20'hFFFFF, and the recorder state enum.
REQ-035 The sub-module aud_i2s_rx (LRC edge detection, delay-bit skip, 16-bit shifter, sample-valid pulse) SHALL be instantiated once; aud_recorder SHALL own the state machine, addressing and peak logic.

Verification
REQ-036 Bench SHALL cover: start, then one left frame carrying 16'hA5C3 -> o_write one cycle at 17 cycles after LRC fall, o_data = A5C3, o_address = 0; next cycle o_address = 1, o_end_addr = 0.
REQ-037 Bench SHALL cover: three frames 0001/8000/7FFE with AUD_REC_PEAK_EN -> writes at addresses 0, 1, 2; o_peak = 7FFF; without the macro o_peak = 0.
REQ-038 Bench SHALL cover: i_stop at bit 8 of the second sample -> only one write; S_IDLE next cycle; o_end_addr = 0; o_address = 1.
REQ-039 Bench SHALL cover: i_pause asserted mid-sample -> that sample written, then no writes for 4 frames; release -> capture resumes at the next LRC fall.
REQ-040 Bench SHALL cover: preload o_address to FFFFE via recording, then 2 frames -> writes at FFFFE and FFFFF; o_full = 1; S_IDLE; o_address = FFFFF with no wrap.
REQ-041 Bench SHALL cover: i_rst_n low during S_SHIFT -> all outputs 0 asynchronously, no o_write; a later i_start records from address 0.
